// File: rtl/axi4_arb_pkg.sv
// rtl/axi4_arb_pkg.sv - shared types and AXI encodings for the two-master AXI4 arbiter
package axi4_arb_pkg;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_BUSY = 1'b1
  } wr_state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way requester pick; AXI_ARB_FIXED_PRIO_EN selects fixed s0 priority
module rr_pick2
  import axi4_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       gnt
);

`ifdef AXI_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ptr;

  always_comb begin
    gnt = ~req[0] & req[1];
  end
`else
  // ptr names the preferred master; the other wins only when ptr is not requesting
  always_comb begin
    gnt = req[ptr] ? ptr : ~ptr;
  end
`endif

endmodule

// File: rtl/axi4_rr_arbiter.sv
// rtl/axi4_rr_arbiter.sv - two-master to one-slave AXI4 arbiter with independent read/write grants
// AXI_ARB_FIXED_PRIO_EN: s0 wins simultaneous requests, no round-robin pointers
module axi4_rr_arbiter
  import axi4_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s0_arvalid, s1_arvalid,
  output logic                s0_arready, s1_arready,
  input  logic [ADDR_W-1:0]   s0_araddr, s1_araddr,
  input  logic [ID_W-1:0]     s0_arid, s1_arid,
  input  logic [7:0]          s0_arlen, s1_arlen,
  input  logic [2:0]          s0_arsize, s1_arsize,
  input  logic [1:0]          s0_arburst, s1_arburst,
  output logic                s0_rvalid, s1_rvalid,
  input  logic                s0_rready, s1_rready,
  output logic [DATA_W-1:0]   s0_rdata, s1_rdata,
  output logic [ID_W-1:0]     s0_rid, s1_rid,
  output logic [1:0]          s0_rresp, s1_rresp,
  output logic                s0_rlast, s1_rlast,
  input  logic                s0_awvalid, s1_awvalid,
  output logic                s0_awready, s1_awready,
  input  logic [ADDR_W-1:0]   s0_awaddr, s1_awaddr,
  input  logic [ID_W-1:0]     s0_awid, s1_awid,
  input  logic [7:0]          s0_awlen, s1_awlen,
  input  logic [2:0]          s0_awsize, s1_awsize,
  input  logic [1:0]          s0_awburst, s1_awburst,
  input  logic                s0_wvalid, s1_wvalid,
  output logic                s0_wready, s1_wready,
  input  logic [DATA_W-1:0]   s0_wdata, s1_wdata,
  input  logic [DATA_W/8-1:0] s0_wstrb, s1_wstrb,
  input  logic                s0_wlast, s1_wlast,
  output logic                s0_bvalid, s1_bvalid,
  input  logic                s0_bready, s1_bready,
  output logic [ID_W-1:0]     s0_bid, s1_bid,
  output logic [1:0]          s0_bresp, s1_bresp,
  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [ID_W:0]       m_arid,
  output logic [7:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [ID_W:0]       m_rid,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [ID_W:0]       m_awid,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  input  logic                m_bvalid,
  output logic                m_bready,
  input  logic [ID_W:0]       m_bid,
  input  logic [1:0]          m_bresp
);

  logic      rd_gnt_vld, rd_gnt, rd_pick, rd_pref;
  logic      wr_gnt, wr_pick, wr_pref;
  logic      aw_done, w_done;
  wr_state_t wr_state;
  logic      wr_busy, aw_hs, wl_hs;

`ifdef AXI_ARB_FIXED_PRIO_EN
  assign rd_pref = 1'b0;
  assign wr_pref = 1'b0;
`else
  logic rd_ptr, wr_ptr;
  assign rd_pref = rd_ptr;
  assign wr_pref = wr_ptr;
`endif

  rr_pick2 u_ar_pick (.req({s1_arvalid, s0_arvalid}), .ptr(rd_pref), .gnt(rd_pick));
  rr_pick2 u_aw_pick (.req({s1_awvalid, s0_awvalid}), .ptr(wr_pref), .gnt(wr_pick));

  // Read grant is held from the cycle after a request until its AR handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_gnt_vld <= 1'b0;
      rd_gnt     <= 1'b0;
`ifndef AXI_ARB_FIXED_PRIO_EN
      rd_ptr     <= 1'b0;
`endif
    end else if (!rd_gnt_vld) begin
      if (s0_arvalid || s1_arvalid) begin
        rd_gnt_vld <= 1'b1;
        rd_gnt     <= rd_pick;
      end
    end else if (m_arvalid && m_arready) begin
      rd_gnt_vld <= 1'b0;
`ifndef AXI_ARB_FIXED_PRIO_EN
      rd_ptr     <= ~rd_gnt;
`endif
    end
  end

  always_comb begin
    m_arvalid  = rd_gnt_vld & (rd_gnt ? s1_arvalid : s0_arvalid);
    m_araddr   = rd_gnt ? s1_araddr  : s0_araddr;
    m_arid     = {rd_gnt, (rd_gnt ? s1_arid : s0_arid)};
    m_arlen    = rd_gnt ? s1_arlen   : s0_arlen;
    m_arsize   = rd_gnt ? s1_arsize  : s0_arsize;
    m_arburst  = rd_gnt ? s1_arburst : s0_arburst;
    s0_arready = rd_gnt_vld & ~rd_gnt & m_arready;
    s1_arready = rd_gnt_vld &  rd_gnt & m_arready;
  end

  // R and B return paths are steered by the master bit prepended to the ID
  always_comb begin
    s0_rvalid = m_rvalid & ~m_rid[ID_W];
    s1_rvalid = m_rvalid &  m_rid[ID_W];
    m_rready  = m_rid[ID_W] ? s1_rready : s0_rready;
    s0_rdata  = m_rdata;
    s1_rdata  = m_rdata;
    s0_rid    = m_rid[ID_W-1:0];
    s1_rid    = m_rid[ID_W-1:0];
    s0_rresp  = m_rresp;
    s1_rresp  = m_rresp;
    s0_rlast  = m_rlast;
    s1_rlast  = m_rlast;
    s0_bvalid = m_bvalid & ~m_bid[ID_W];
    s1_bvalid = m_bvalid &  m_bid[ID_W];
    m_bready  = m_bid[ID_W] ? s1_bready : s0_bready;
    s0_bid    = m_bid[ID_W-1:0];
    s1_bid    = m_bid[ID_W-1:0];
    s0_bresp  = m_bresp;
    s1_bresp  = m_bresp;
  end

  assign wr_busy = (wr_state == W_BUSY);
  assign aw_hs   = m_awvalid & m_awready;
  assign wl_hs   = m_wvalid & m_wready & m_wlast;

  // Completion counts handshakes of the current cycle so the FSM leaves without an extra bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= W_IDLE;
      wr_gnt   <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
`ifndef AXI_ARB_FIXED_PRIO_EN
      wr_ptr   <= 1'b0;
`endif
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (s0_awvalid || s1_awvalid) begin
            wr_state <= W_BUSY;
            wr_gnt   <= wr_pick;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
          end
        end
        W_BUSY: begin
          if ((aw_done || aw_hs) && (w_done || wl_hs)) begin
            wr_state <= W_IDLE;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
`ifndef AXI_ARB_FIXED_PRIO_EN
            wr_ptr   <= ~wr_gnt;
`endif
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (wl_hs) w_done  <= 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    m_awvalid  = wr_busy & ~aw_done & (wr_gnt ? s1_awvalid : s0_awvalid);
    m_awaddr   = wr_gnt ? s1_awaddr  : s0_awaddr;
    m_awid     = {wr_gnt, (wr_gnt ? s1_awid : s0_awid)};
    m_awlen    = wr_gnt ? s1_awlen   : s0_awlen;
    m_awsize   = wr_gnt ? s1_awsize  : s0_awsize;
    m_awburst  = wr_gnt ? s1_awburst : s0_awburst;
    s0_awready = wr_busy & ~aw_done & ~wr_gnt & m_awready;
    s1_awready = wr_busy & ~aw_done &  wr_gnt & m_awready;
    m_wvalid   = wr_busy & ~w_done & (wr_gnt ? s1_wvalid : s0_wvalid);
    m_wdata    = wr_gnt ? s1_wdata : s0_wdata;
    m_wstrb    = wr_gnt ? s1_wstrb : s0_wstrb;
    m_wlast    = wr_gnt ? s1_wlast : s0_wlast;
    s0_wready  = wr_busy & ~w_done & ~wr_gnt & m_wready;
    s1_wready  = wr_busy & ~w_done &  wr_gnt & m_wready;
  end

endmodule

// File: tb/tb_axi4_rr_arbiter.sv
// tb/tb_axi4_rr_arbiter.sv - directed self-checking bench for axi4_rr_arbiter
module tb_axi4_rr_arbiter;
  import axi4_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          s0_arvalid, s1_arvalid, s0_arready, s1_arready;
  logic [AW-1:0] s0_araddr, s1_araddr;
  logic [IW-1:0] s0_arid, s1_arid;
  logic [7:0]    s0_arlen, s1_arlen;
  logic [2:0]    s0_arsize, s1_arsize;
  logic [1:0]    s0_arburst, s1_arburst;
  logic          s0_rvalid, s1_rvalid, s0_rready, s1_rready;
  logic [DW-1:0] s0_rdata, s1_rdata;
  logic [IW-1:0] s0_rid, s1_rid;
  logic [1:0]    s0_rresp, s1_rresp;
  logic          s0_rlast, s1_rlast;
  logic          s0_awvalid, s1_awvalid, s0_awready, s1_awready;
  logic [AW-1:0] s0_awaddr, s1_awaddr;
  logic [IW-1:0] s0_awid, s1_awid;
  logic [7:0]    s0_awlen, s1_awlen;
  logic [2:0]    s0_awsize, s1_awsize;
  logic [1:0]    s0_awburst, s1_awburst;
  logic          s0_wvalid, s1_wvalid, s0_wready, s1_wready;
  logic [DW-1:0] s0_wdata, s1_wdata;
  logic [3:0]    s0_wstrb, s1_wstrb;
  logic          s0_wlast, s1_wlast;
  logic          s0_bvalid, s1_bvalid, s0_bready, s1_bready;
  logic [IW-1:0] s0_bid, s1_bid;
  logic [1:0]    s0_bresp, s1_bresp;
  logic          m_arvalid, m_arready;
  logic [AW-1:0] m_araddr;
  logic [IW:0]   m_arid;
  logic [7:0]    m_arlen;
  logic [2:0]    m_arsize;
  logic [1:0]    m_arburst;
  logic          m_rvalid, m_rready;
  logic [DW-1:0] m_rdata;
  logic [IW:0]   m_rid;
  logic [1:0]    m_rresp;
  logic          m_rlast;
  logic          m_awvalid, m_awready;
  logic [AW-1:0] m_awaddr;
  logic [IW:0]   m_awid;
  logic [7:0]    m_awlen;
  logic [2:0]    m_awsize;
  logic [1:0]    m_awburst;
  logic          m_wvalid, m_wready;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_wstrb;
  logic          m_wlast;
  logic          m_bvalid, m_bready;
  logic [IW:0]   m_bid;
  logic [1:0]    m_bresp;

  axi4_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .s0_arvalid(s0_arvalid), .s1_arvalid(s1_arvalid), .s0_arready(s0_arready), .s1_arready(s1_arready),
    .s0_araddr(s0_araddr), .s1_araddr(s1_araddr), .s0_arid(s0_arid), .s1_arid(s1_arid),
    .s0_arlen(s0_arlen), .s1_arlen(s1_arlen), .s0_arsize(s0_arsize), .s1_arsize(s1_arsize),
    .s0_arburst(s0_arburst), .s1_arburst(s1_arburst),
    .s0_rvalid(s0_rvalid), .s1_rvalid(s1_rvalid), .s0_rready(s0_rready), .s1_rready(s1_rready),
    .s0_rdata(s0_rdata), .s1_rdata(s1_rdata), .s0_rid(s0_rid), .s1_rid(s1_rid),
    .s0_rresp(s0_rresp), .s1_rresp(s1_rresp), .s0_rlast(s0_rlast), .s1_rlast(s1_rlast),
    .s0_awvalid(s0_awvalid), .s1_awvalid(s1_awvalid), .s0_awready(s0_awready), .s1_awready(s1_awready),
    .s0_awaddr(s0_awaddr), .s1_awaddr(s1_awaddr), .s0_awid(s0_awid), .s1_awid(s1_awid),
    .s0_awlen(s0_awlen), .s1_awlen(s1_awlen), .s0_awsize(s0_awsize), .s1_awsize(s1_awsize),
    .s0_awburst(s0_awburst), .s1_awburst(s1_awburst),
    .s0_wvalid(s0_wvalid), .s1_wvalid(s1_wvalid), .s0_wready(s0_wready), .s1_wready(s1_wready),
    .s0_wdata(s0_wdata), .s1_wdata(s1_wdata), .s0_wstrb(s0_wstrb), .s1_wstrb(s1_wstrb),
    .s0_wlast(s0_wlast), .s1_wlast(s1_wlast),
    .s0_bvalid(s0_bvalid), .s1_bvalid(s1_bvalid), .s0_bready(s0_bready), .s1_bready(s1_bready),
    .s0_bid(s0_bid), .s1_bid(s1_bid), .s0_bresp(s0_bresp), .s1_bresp(s1_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rid(m_rid),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_id_c, exp_id_e;

  initial begin
    rst = 1'b1;
    {s0_arvalid, s1_arvalid, s0_awvalid, s1_awvalid, s0_wvalid, s1_wvalid} = '0;
    {s0_araddr, s1_araddr, s0_awaddr, s1_awaddr} = '0;
    {s0_arid, s1_arid, s0_awid, s1_awid} = '0;
    {s0_arlen, s1_arlen, s0_awlen, s1_awlen} = '0;
    {s0_arsize, s1_arsize, s0_awsize, s1_awsize} = {4{3'd2}};
    {s0_arburst, s1_arburst, s0_awburst, s1_awburst} = {4{BURST_INCR}};
    {s0_wdata, s1_wdata} = '0;
    {s0_wstrb, s1_wstrb} = 8'hFF;
    {s0_wlast, s1_wlast} = '0;
    {s0_rready, s1_rready, s0_bready, s1_bready} = '0;
    m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
    m_rvalid = 1'b0; m_rdata = '0; m_rid = '0; m_rresp = RESP_OKAY; m_rlast = 1'b0;
    m_bvalid = 1'b0; m_bid = '0; m_bresp = RESP_OKAY;

    // reset state
    tick(); tick();
    chk("rst_m_arvalid", m_arvalid, 0);
    chk("rst_m_awvalid", m_awvalid, 0);
    chk("rst_m_wvalid", m_wvalid, 0);
    chk("rst_s0_arready", s0_arready, 0);
    chk("rst_s1_awready", s1_awready, 0);
    chk("rst_s0_rvalid", s0_rvalid, 0);
    rst = 1'b0;

    // 1: single s0 read, one bubble, R routed to s0
    tick();
    s0_arvalid = 1'b1; s0_araddr = 32'h1000; s0_arid = 15'd5;
    #1 chk("t1_bubble", m_arvalid, 0);
    tick();
    chk("t1_m_arvalid", m_arvalid, 1);
    chk("t1_m_arid", m_arid, 32'h0005);
    chk("t1_m_araddr", m_araddr, 32'h1000);
    chk("t1_s0_arready", s0_arready, 1);
    chk("t1_s1_arready", s1_arready, 0);
    tick();
    s0_arvalid = 1'b0;
    #1 chk("t1_released", m_arvalid, 0);
    m_rvalid = 1'b1; m_rid = 16'h0005; m_rdata = 32'hCAFE0001; m_rlast = 1'b1;
    s0_rready = 1'b1; s1_rready = 1'b1;
    #1 chk("t1_s0_rvalid", s0_rvalid, 1);
    chk("t1_s1_rvalid", s1_rvalid, 0);
    chk("t1_s0_rid", s0_rid, 32'h5);
    chk("t1_s0_rdata", s0_rdata, 32'hCAFE0001);
    chk("t1_m_rready", m_rready, 1);
    m_rvalid = 1'b0;

    // 2: simultaneous AR from a fresh reset, then s0 re-requests while s1 waits
    rst = 1'b1; tick(); rst = 1'b0; tick();
    s0_arvalid = 1'b1; s0_arid = 15'd1; s1_arvalid = 1'b1; s1_arid = 15'd2;
    tick();
    chk("t2_first", m_arid, 32'h0001);
    tick();
    s0_arid = 15'd3;
    #1 chk("t2_bubble", m_arvalid, 0);
`ifdef AXI_ARB_FIXED_PRIO_EN
    exp_id_c = 16'h0003; exp_id_e = 16'h8002;
`else
    exp_id_c = 16'h8002; exp_id_e = 16'h0003;
`endif
    tick();
    chk("t2_second", m_arid, {16'h0, exp_id_c});
    tick();
    if (exp_id_c[15]) s1_arvalid = 1'b0; else s0_arvalid = 1'b0;
    tick();
    chk("t2_third", m_arid, {16'h0, exp_id_e});
    chk("t2_third_valid", m_arvalid, 1);
    tick();
    s0_arvalid = 1'b0; s1_arvalid = 1'b0;
    #1 chk("t2_idle", m_arvalid, 0);

    // 4: interleaved R beats, s1 stalled
    s0_rready = 1'b1; s1_rready = 1'b0; m_rvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      m_rid = (k % 2 == 1) ? 16'h8003 : 16'h0003;
      m_rdata = 32'hD000 + k;
      #1;
      if (k % 2 == 0) begin
        chk("t4_s0_rvalid", s0_rvalid, 1);
        chk("t4_s1_rvalid_off", s1_rvalid, 0);
        chk("t4_m_rready_s0", m_rready, 1);
        chk("t4_s0_rdata", s0_rdata, 32'hD000 + k);
      end else begin
        chk("t4_s1_rvalid", s1_rvalid, 1);
        chk("t4_s0_rvalid_off", s0_rvalid, 0);
        chk("t4_m_rready_s1", m_rready, 0);
        chk("t4_s1_rid", s1_rid, 32'h3);
      end
    end
    m_rvalid = 1'b0;

    // 3: s1 4-beat write, W leads AW by two cycles
    tick();
    s1_wvalid = 1'b1; s1_wdata = 32'hA0; s1_wlast = 1'b0;
    #1 chk("t3_w_early0", m_wvalid, 0);
    chk("t3_wready_early0", s1_wready, 0);
    tick();
    chk("t3_w_early1", m_wvalid, 0);
    tick();
    s1_awvalid = 1'b1; s1_awid = 15'd2; s1_awlen = 8'd3; s1_awaddr = 32'h2000;
    #1 chk("t3_aw_bubble", m_awvalid, 0);
    tick();
    for (int b = 0; b < 4; b++) begin
      s1_wdata = 32'hA0 + b; s1_wlast = (b == 3);
      #1 chk("t3_m_wvalid", m_wvalid, 1);
      chk("t3_m_wdata", m_wdata, 32'hA0 + b);
      chk("t3_m_wlast", m_wlast, (b == 3) ? 32'h1 : 32'h0);
      chk("t3_s1_wready", s1_wready, 1);
      chk("t3_s0_awready", s0_awready, 0);
      chk("t3_s0_wready", s0_wready, 0);
      if (b == 0) begin
        chk("t3_m_awvalid", m_awvalid, 1);
        chk("t3_m_awid", m_awid, 32'h8002);
        chk("t3_m_awlen", m_awlen, 32'h3);
      end else begin
        chk("t3_aw_done", m_awvalid, 0);
      end
      tick();
      if (b == 0) s1_awvalid = 1'b0;
    end
    s1_wvalid = 1'b0; s1_wlast = 1'b0;
    #1 chk("t3_w_idle", m_wvalid, 0);

    // 5: s0 write with aw_done and 2 of 4 beats, then reset
    m_awready = 1'b0;
    s0_awvalid = 1'b1; s0_awid = 15'd1; s0_awlen = 8'd3;
    tick();
    chk("t5_grant_s0", m_awid, 32'h0001);
    chk("t5_awvalid", m_awvalid, 1);
    m_awready = 1'b1; s0_wvalid = 1'b1; s0_wdata = 32'hB0; s0_wlast = 1'b0;
    tick();
    s0_awvalid = 1'b0; s0_wdata = 32'hB1;
    tick();
    chk("t5_aw_done", m_awvalid, 0);
    chk("t5_w_mid", m_wvalid, 1);
    rst = 1'b1;
    s0_arvalid = 1'b1; s0_arid = 15'h11; s1_arvalid = 1'b1; s1_arid = 15'h22;
    tick();
    rst = 1'b0;
    chk("t5_m_wvalid", m_wvalid, 0);
    chk("t5_s0_wready", s0_wready, 0);
    chk("t5_m_awvalid", m_awvalid, 0);
    chk("t5_m_arvalid", m_arvalid, 0);
    chk("t5_s1_arready", s1_arready, 0);
    s0_wvalid = 1'b0;
    tick();
    chk("t5_rd_ptr_reset", m_arid, 32'h0011);
    tick();
    s0_arvalid = 1'b0; s1_arvalid = 1'b0;

    // 6: concurrent s0 read and s1 write, then B routing
    tick();
    s0_arvalid = 1'b1; s0_arid = 15'd4; s0_araddr = 32'h3000;
    s1_awvalid = 1'b1; s1_awid = 15'd7; s1_awlen = 8'd0;
    s1_wvalid = 1'b1; s1_wdata = 32'hEE; s1_wlast = 1'b1;
    tick();
    chk("t6_m_arvalid", m_arvalid, 1);
    chk("t6_m_awvalid", m_awvalid, 1);
    chk("t6_m_arid", m_arid, 32'h0004);
    chk("t6_m_awid", m_awid, 32'h8007);
    chk("t6_m_wvalid", m_wvalid, 1);
    tick();
    s0_arvalid = 1'b0; s1_awvalid = 1'b0; s1_wvalid = 1'b0; s1_wlast = 1'b0;
    #1 chk("t6_w_released", m_awvalid, 0);
    m_bvalid = 1'b1; m_bid = 16'h8007; m_bresp = RESP_OKAY; s1_bready = 1'b1; s0_bready = 1'b0;
    #1 chk("t6_s1_bvalid", s1_bvalid, 1);
    chk("t6_s0_bvalid", s0_bvalid, 0);
    chk("t6_s1_bid", s1_bid, 32'h7);
    chk("t6_m_bready", m_bready, 1);
    m_bid = 16'h0007; m_bresp = RESP_SLVERR;
    #1 chk("t6_s0_bvalid_b", s0_bvalid, 1);
    chk("t6_s1_bvalid_b", s1_bvalid, 0);
    chk("t6_m_bready_b", m_bready, 0);
    chk("t6_s0_bresp", s0_bresp, 32'h2);
    m_bvalid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
